// File: rtl/memory_bus_arbiter_pkg.sv
// Shared bus definitions for the memory bus arbiter.
// Holds the default bus widths and the port-index to master-ID mapping.
package memory_bus_arbiter_pkg;

    localparam int ADDRESS_WIDTH = 32;
    localparam int DATA_WIDTH    = 24;
    localparam int ID_WIDTH      = 4;

    // Port i on an arbiter with base id_base carries master ID id_base+i.
    // Returned as a full int so callers cast to their own ID width.
    function automatic int unsigned master_id(input int unsigned id_base,
                                              input int unsigned port);
        return id_base + port;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin priority selector.
// Ports:
//   eligible     in   N     requesters allowed to win this cycle
//   ptr          in   PW    last granted index; search starts at ptr+1
//   grant_valid  out  1     some requester is eligible
//   grant_idx    out  PW    winning index (0 when grant_valid=0)
module rr_select #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible,
    input  logic [PW-1:0] ptr,
    output logic          grant_valid,
    output logic [PW-1:0] grant_idx
);

    // Walk offsets from farthest to nearest so the nearest eligible
    // port after ptr is the last one written and therefore wins.
    always_comb begin
        int idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int off = N; off >= 1; off--) begin
            idx = (int'(ptr) + off) % N;
            if (eligible[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Memory bus arbiter: NUM_MASTERS request ports share one downstream port.
// Requests are granted round-robin into a single output register; reads are
// throttled per port to MAX_OUTSTANDING in flight. Responses are broadcast
// back to all ports and steered by ID.
// Ports:
//   clock, reset                     clock, synchronous active-high reset
//   mMsValid/Taken/Address/Data/Write  per-port request handshake
//   mSmValid/Taken/ID/Data           per-port response (broadcast)
//   sMsValid/Taken/ID/Address/Data/Write  downstream request
//   sSmValid/Taken/ID/Data           downstream response
module memory_bus_arbiter
    import memory_bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS     = 4,
    parameter int DATA_WIDTH      = memory_bus_arbiter_pkg::DATA_WIDTH,
    parameter int ADDRESS_WIDTH   = memory_bus_arbiter_pkg::ADDRESS_WIDTH,
    parameter int ID_WIDTH        = memory_bus_arbiter_pkg::ID_WIDTH,
    parameter int ID_BASE         = 0,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                       clock,
    input  logic                                       reset,
    input  logic [NUM_MASTERS-1:0]                     mMsValid,
    output logic [NUM_MASTERS-1:0]                     mMsTaken,
    input  logic [NUM_MASTERS-1:0][ADDRESS_WIDTH-1:0]  mMsAddress,
    input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]     mMsData,
    input  logic [NUM_MASTERS-1:0]                     mMsWrite,
    output logic [NUM_MASTERS-1:0]                     mSmValid,
    input  logic [NUM_MASTERS-1:0]                     mSmTaken,
    output logic [NUM_MASTERS-1:0][ID_WIDTH-1:0]       mSmID,
    output logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]     mSmData,
    output logic                                       sMsValid,
    input  logic                                       sMsTaken,
    output logic [ID_WIDTH-1:0]                        sMsID,
    output logic [ADDRESS_WIDTH-1:0]                   sMsAddress,
    output logic [DATA_WIDTH-1:0]                      sMsData,
    output logic                                       sMsWrite,
    input  logic                                       sSmValid,
    output logic                                       sSmTaken,
    input  logic [ID_WIDTH-1:0]                        sSmID,
    input  logic [DATA_WIDTH-1:0]                      sSmData
);

    localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [PW-1:0]                   ptr;
    logic [NUM_MASTERS-1:0][CW-1:0]  outstanding;
    logic [NUM_MASTERS-1:0]          eligible, id_hit, inc, dec;
    logic                            grant_valid, grant, can_load;
    logic [PW-1:0]                   grant_idx;

    always_comb begin
        eligible = '0;
        id_hit   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            eligible[i] = mMsValid[i] &&
                          (mMsWrite[i] || (outstanding[i] < CW'(MAX_OUTSTANDING)));
            id_hit[i]   = (sSmID == ID_WIDTH'(master_id(ID_BASE, i)));
        end
    end

    rr_select #(.N(NUM_MASTERS), .PW(PW)) u_rr_select (
        .eligible    (eligible),
        .ptr         (ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Output register can accept a new request if empty or draining this cycle.
    assign can_load = !sMsValid || sMsTaken;
    assign grant    = grant_valid && can_load && !reset;

    always_comb begin
        mMsTaken = '0;
        inc      = '0;
        dec      = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            mMsTaken[i] = grant && (grant_idx == PW'(i));
            inc[i]      = mMsTaken[i] && !mMsWrite[i];
            dec[i]      = sSmValid && mSmTaken[i] && id_hit[i];
        end
    end

    // Unknown IDs are swallowed so a stray response cannot stall the bus.
    assign sSmTaken = (|(mSmTaken & id_hit)) || !(|id_hit);

    assign mSmValid = {NUM_MASTERS{sSmValid}};
    assign mSmID    = {NUM_MASTERS{sSmID}};
    assign mSmData  = {NUM_MASTERS{sSmData}};

    always_ff @(posedge clock) begin
        if (reset) begin
            sMsValid    <= 1'b0;
            sMsID       <= '0;
            sMsAddress  <= '0;
            sMsData     <= '0;
            sMsWrite    <= 1'b0;
            ptr         <= PW'(NUM_MASTERS - 1);
            outstanding <= '0;
        end else begin
            if (grant) begin
                sMsValid   <= 1'b1;
                sMsID      <= ID_WIDTH'(master_id(ID_BASE, int'(grant_idx)));
                sMsAddress <= mMsAddress[grant_idx];
                sMsData    <= mMsData[grant_idx];
                sMsWrite   <= mMsWrite[grant_idx];
                ptr        <= grant_idx;
            end else if (sMsTaken) begin
                sMsValid <= 1'b0;
            end
            // Increment and decrement together cancel; decrement at 0 saturates.
            for (int i = 0; i < NUM_MASTERS; i++) begin
                case ({inc[i], dec[i]})
                    2'b10:   outstanding[i] <= outstanding[i] + 1'b1;
                    2'b01:   if (outstanding[i] != '0) outstanding[i] <= outstanding[i] - 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Self-checking bench for memory_bus_arbiter: directed scenarios followed by
// randomized traffic, all checked against a transaction-level model.
module tb_memory_bus_arbiter;

    localparam int NM   = 4;
    localparam int DW   = 24;
    localparam int AW   = 32;
    localparam int IW   = 4;
    localparam int BASE = 2;
    localparam int MAXO = 4;

    logic                    clock = 1'b0;
    logic                    reset;
    logic [NM-1:0]           mMsValid, mMsTaken, mMsWrite;
    logic [NM-1:0][AW-1:0]   mMsAddress;
    logic [NM-1:0][DW-1:0]   mMsData;
    logic [NM-1:0]           mSmValid, mSmTaken;
    logic [NM-1:0][IW-1:0]   mSmID;
    logic [NM-1:0][DW-1:0]   mSmData;
    logic                    sMsValid, sMsTaken, sMsWrite;
    logic [IW-1:0]           sMsID;
    logic [AW-1:0]           sMsAddress;
    logic [DW-1:0]           sMsData;
    logic                    sSmValid, sSmTaken;
    logic [IW-1:0]           sSmID;
    logic [DW-1:0]           sSmData;

    memory_bus_arbiter #(
        .NUM_MASTERS(NM), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW),
        .ID_WIDTH(IW), .ID_BASE(BASE), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clock(clock), .reset(reset),
        .mMsValid(mMsValid), .mMsTaken(mMsTaken), .mMsAddress(mMsAddress),
        .mMsData(mMsData), .mMsWrite(mMsWrite),
        .mSmValid(mSmValid), .mSmTaken(mSmTaken), .mSmID(mSmID), .mSmData(mSmData),
        .sMsValid(sMsValid), .sMsTaken(sMsTaken), .sMsID(sMsID),
        .sMsAddress(sMsAddress), .sMsData(sMsData), .sMsWrite(sMsWrite),
        .sSmValid(sSmValid), .sSmTaken(sSmTaken), .sSmID(sSmID), .sSmData(sSmData)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: contents of the downstream request slot, the last
    // winner, and the number of reads each port has in flight.
    bit            m_valid;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    bit            m_write;
    int            m_id;
    int            m_last;
    int            m_out [NM];

    logic [NM-1:0] obs_taken;
    logic          obs_stk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_addr = '0; m_data = '0; m_write = 0; m_id = 0;
        m_last  = NM - 1;
        for (int i = 0; i < NM; i++) m_out[i] = 0;
    endtask

    task automatic idle();
        reset = 0; mMsValid = '0; mMsWrite = '0; mMsAddress = '0; mMsData = '0;
        mSmTaken = '0; sMsTaken = 1; sSmValid = 0; sSmID = '0; sSmData = '0;
    endtask

    // Called at posedge+1 with inputs already driven: checks this cycle's
    // outputs against the model, then advances the model across the edge.
    task automatic step();
        bit            gv, inr;
        int            g, rid;
        logic [NM-1:0] exp_taken;
        #2;
        gv = 0; g = 0;
        if (!reset && (!m_valid || sMsTaken)) begin
            for (int k = 1; k <= NM; k++) begin
                int p;
                p = (m_last + k) % NM;
                if (!gv && mMsValid[p] && (mMsWrite[p] || m_out[p] < MAXO)) begin
                    gv = 1; g = p;
                end
            end
        end
        exp_taken = gv ? NM'(1 << g) : '0;
        rid = int'(sSmID);
        inr = (rid >= BASE) && (rid < BASE + NM);
        obs_taken = mMsTaken;
        obs_stk   = sSmTaken;
        chk("mMsTaken", mMsTaken, exp_taken);
        chk("sMsValid", sMsValid, m_valid);
        chk("sMsAddress", sMsAddress, m_addr);
        chk("sMsData", sMsData, m_data);
        chk("sMsWrite", sMsWrite, m_write);
        chk("sMsID", sMsID, m_id);
        chk("sSmTaken", sSmTaken, inr ? mSmTaken[rid - BASE] : 1'b1);
        chk("mSmValid", mSmValid, sSmValid ? {NM{1'b1}} : {NM{1'b0}});
        for (int k = 0; k < NM; k++) begin
            chk("mSmID", mSmID[k], sSmID);
            chk("mSmData", mSmData[k], sSmData);
        end
        @(posedge clock);
        if (reset) begin
            model_reset();
        end else begin
            if (gv) begin
                m_valid = 1; m_addr = mMsAddress[g]; m_data = mMsData[g];
                m_write = mMsWrite[g]; m_id = BASE + g; m_last = g;
                if (!mMsWrite[g]) m_out[g]++;
            end else if (sMsTaken) begin
                m_valid = 0;
            end
            if (sSmValid && inr && mSmTaken[rid - BASE] && m_out[rid - BASE] > 0)
                m_out[rid - BASE]--;
        end
        #1;
    endtask

    task automatic reset_cycle();
        idle(); reset = 1; step(); reset = 0;
    endtask

    initial begin
        int ng;
        idle();
        reset = 1;
        @(posedge clock); #1;
        model_reset();
        reset = 0;

        // Alternating grants between ports 0 and 2.
        step();
        mMsValid = 4'b0101; sMsTaken = 1;
        mMsAddress[0] = 32'h1000; mMsAddress[2] = 32'h2000;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("alt_grant", obs_taken, (k % 2) ? 4'b0100 : 4'b0001);
            chk("alt_id", sMsID, BASE + ((k % 2) ? 2 : 0));
        end

        // Reset while a request is pending; then lowest eligible wins.
        reset = 1; step(); reset = 0;
        chk("rst_valid", sMsValid, 1'b0);
        mMsValid = 4'b0110;
        step();
        chk("post_rst_grant", obs_taken, 4'b0010);
        chk("post_rst_id", sMsID, BASE + 1);

        // Read throttling on port 1.
        reset_cycle();
        mMsValid = 4'b0010; sMsTaken = 1;
        ng = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            ng += int'(obs_taken[1]);
        end
        chk("throttle_grants", ng, 4);
        sSmValid = 1; sSmID = IW'(BASE + 1); mSmTaken = 4'b0010;
        step();
        chk("throttle_same_cycle", obs_taken[1], 1'b0);
        sSmValid = 0; mSmTaken = '0;
        step();
        chk("throttle_fifth", obs_taken[1], 1'b1);

        // Downstream stall holds the request slot.
        reset_cycle();
        mMsValid = 4'b0001; mMsWrite = 4'b0001;
        mMsAddress[0] = 32'h100; mMsData[0] = 24'hABC;
        step();
        mMsAddress[0] = 32'h200; mMsData[0] = 24'h123; sMsTaken = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_taken", obs_taken, 4'b0000);
            chk("stall_addr", sMsAddress, 32'h100);
            chk("stall_data", sMsData, 24'hABC);
        end
        sMsTaken = 1;
        step();
        chk("stall_release", obs_taken, 4'b0001);

        // Response routing, including an ID outside the port range.
        reset_cycle();
        mMsValid = 4'b1000;
        step();
        mMsValid = '0;
        sSmValid = 1; sSmID = IW'(BASE + 3); mSmTaken = 4'b1000;
        step();
        chk("resp_hit", obs_stk, 1'b1);
        sSmID = IW'(BASE + 7); mSmTaken = '0;
        step();
        chk("resp_stray", obs_stk, 1'b1);
        sSmID = IW'(BASE + 3);
        step();
        chk("resp_not_taken", obs_stk, 1'b0);

        // Randomized traffic.
        idle();
        for (int c = 0; c < 3000; c++) begin
            reset    = ($urandom_range(0, 199) == 0);
            mMsValid = NM'($urandom);
            mMsWrite = NM'($urandom & $urandom);
            for (int i = 0; i < NM; i++) begin
                mMsAddress[i] = $urandom;
                mMsData[i]    = DW'($urandom);
            end
            sMsTaken = ($urandom_range(0, 3) != 0);
            sSmValid = ($urandom_range(0, 2) == 0);
            sSmID    = IW'($urandom_range(0, 9));
            sSmData  = DW'($urandom);
            mSmTaken = NM'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
